// File: rtl/matrix_loader.sv
// Fill stage for one matrix store: takes a valid/ready element stream and writes it
// row-major (or transposed) through the store write port, zero-filling after an early last.
module matrix_loader #(
    parameter int MATRIX_DIM = 16,
    parameter int DATA_W     = 16,
    localparam int LENGTH    = MATRIX_DIM * MATRIX_DIM,
    localparam int AW        = $clog2(LENGTH),
    localparam int CW        = $clog2(MATRIX_DIM)
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              start_i,
    input  logic              transpose_i,
    input  logic              in_valid_i,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic              in_last_i,
    output logic              in_ready_o,
    output logic              mat_we_o,
    output logic [AW-1:0]     mat_addr_o,
    output logic [DATA_W-1:0] mat_D_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              short_load_o
);

    // state | meaning
    // IDLE  | waiting for start; all outputs quiet except the sticky short_load flag
    // LOAD  | accepting stream elements, one store write per handshake
    // FILL  | source ended early; writing zeros to the remaining entries
    // DONE  | one-cycle completion pulse
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] FILL = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    localparam logic [CW-1:0] IDX_MAX = CW'(MATRIX_DIM - 1);

    logic [1:0]        state_q, state_d;
    logic [CW-1:0]     row_q, row_d;
    logic [CW-1:0]     col_q, col_d;
    logic              tr_q, tr_d;
    logic              short_q, short_d;

    logic              in_ready;
    logic              we;
    logic [DATA_W-1:0] wdata;
    logic              busy;
    logic              done;
    logic              advance;
    logic              at_last;
    logic [AW-1:0]     addr;

    assign at_last = (row_q == IDX_MAX) && (col_q == IDX_MAX);
    assign addr    = tr_q ? {col_q, row_q} : {row_q, col_q};

    always_comb begin
        state_d  = state_q;
        row_d    = row_q;
        col_d    = col_q;
        tr_d     = tr_q;
        short_d  = short_q;
        in_ready = 1'b0;
        we       = 1'b0;
        wdata    = '0;
        busy     = 1'b1;
        done     = 1'b0;
        advance  = 1'b0;

        case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (start_i) begin
                    state_d = LOAD;
                    row_d   = '0;
                    col_d   = '0;
                    tr_d    = transpose_i;
                    short_d = 1'b0;
                end
            end
            LOAD: begin
                in_ready = 1'b1;
                if (in_valid_i) begin
                    we      = 1'b1;
                    wdata   = in_data_i;
                    advance = 1'b1;
                    // A last flag on the final entry is redundant, so it is ignored there
                    if (at_last) begin
                        state_d = DONE;
                    end else if (in_last_i) begin
                        state_d = FILL;
                        short_d = 1'b1;
                    end
                end
            end
            FILL: begin
                we      = 1'b1;
                advance = 1'b1;
                if (at_last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                busy    = 1'b0;
                state_d = IDLE;
            end
        endcase

        if (advance) begin
            col_d = col_q + 1'b1;
            if (col_q == IDX_MAX) begin
                row_d = row_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            row_q   <= '0;
            col_q   <= '0;
            tr_q    <= 1'b0;
            short_q <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            tr_q    <= tr_d;
            short_q <= short_d;
        end
    end

    // Reset is synchronous, so outputs are also masked while rst_n is low to keep the
    // store untouched during the reset cycle itself.
    assign in_ready_o   = rst_n_i & in_ready;
    assign mat_we_o     = rst_n_i & we;
    assign mat_addr_o   = (rst_n_i & we) ? addr : '0;
    assign mat_D_o      = rst_n_i ? wdata : '0;
    assign busy_o       = rst_n_i & busy;
    assign done_o       = rst_n_i & done;
    assign short_load_o = rst_n_i & short_q;

endmodule

// File: tb/tb_matrix_loader.sv
// Scoreboard bench for matrix_loader at MATRIX_DIM=4: expected store writes are queued
// when elements are driven and popped when the loader writes.
module tb_matrix_loader;

    localparam int DIM = 4;
    localparam int LEN = DIM * DIM;
    localparam int DW  = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          transpose;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_last;
    logic          in_ready;
    logic          mat_we;
    logic [3:0]    mat_addr;
    logic [DW-1:0] mat_D;
    logic          busy;
    logic          done;
    logic          short_load;

    matrix_loader #(.MATRIX_DIM(DIM), .DATA_W(DW)) dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .start_i      (start),
        .transpose_i  (transpose),
        .in_valid_i   (in_valid),
        .in_data_i    (in_data),
        .in_last_i    (in_last),
        .in_ready_o   (in_ready),
        .mat_we_o     (mat_we),
        .mat_addr_o   (mat_addr),
        .mat_D_o      (mat_D),
        .busy_o       (busy),
        .done_o       (done),
        .short_load_o (short_load)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]    addr;
        logic [DW-1:0] data;
        logic          rdy;
    } exp_t;

    exp_t          expq[$];
    logic [DW-1:0] mem [LEN];
    int            n_checks = 0;
    int            n_fail   = 0;
    int            cyc      = 0;
    int            start_cyc = 0;
    int            done_cyc  = 0;
    int            done_cnt  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int map_addr(input int n, input logic tr);
        return tr ? ((n % DIM) * DIM + n / DIM) : n;
    endfunction

    task automatic push_exp(input int n, input logic tr, input int data, input logic rdy);
        exp_t e;
        e.addr = 4'(map_addr(n, tr));
        e.data = DW'(data);
        e.rdy  = rdy;
        expq.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (rst_n && start && !busy) start_cyc = cyc;
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (mat_we) begin
            if (expq.size() == 0) begin
                check("unexpected_write", 1, 0);
            end else begin
                e = expq.pop_front();
                check("wr_addr", mat_addr, e.addr);
                check("wr_data", mat_D, e.data);
                check("wr_ready", in_ready, e.rdy);
            end
            mem[mat_addr] = mat_D;
        end
    end

    task automatic run_load(input logic tr, input int last_at, input bit last_flag,
                            input bit gaps, input bit poke, input bit chk_lat,
                            input bit exp_short);
        int  k;
        int  base;
        int  nfill;
        bit  v;
        base = done_cnt;
        @(posedge clk); #1;
        start = 1'b1; transpose = tr;
        @(posedge clk); #1;
        start = 1'b0; transpose = 1'b0;
        k = 0;
        while (k <= last_at) begin
            v        = gaps ? bit'($urandom_range(1, 0)) : 1'b1;
            in_valid = v;
            in_data  = DW'(k + 1);
            in_last  = (k == last_at) && last_flag;
            start    = poke ? bit'($urandom_range(1, 0)) : 1'b0;
            if (v) begin
                push_exp(k, tr, k + 1, 1'b1);
                if (in_last && k < LEN - 1)
                    for (int j = k + 1; j < LEN; j++) push_exp(j, tr, 0, 1'b0);
            end
            if (k == 0 && !gaps) begin
                #2;
                check("busy_in_load", busy, 1);
                check("short_cleared", short_load, 0);
                check("ready_in_load", in_ready, 1);
            end
            @(posedge clk); #1;
            if (v) k++;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        nfill    = (last_flag && last_at < LEN - 1) ? (LEN - 1 - last_at) : 0;
        if (poke) begin
            start = 1'b1;
            repeat (nfill + 1) @(posedge clk);
            #1 start = 1'b0;
        end else begin
            start = 1'b0;
        end
        for (int i = 0; i < 60 && done_cnt == base; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        check("done_once", done_cnt - base, 1);
        check("busy_after", busy, 0);
        check("queue_drained", expq.size(), 0);
        check("short_load", short_load, exp_short);
        if (chk_lat) check("start_to_done", done_cyc - start_cyc, LEN + 1);
    endtask

    initial begin
        int base;
        rst_n = 1'b0; start = 1'b0; transpose = 1'b0;
        in_valid = 1'b0; in_data = '0; in_last = 1'b0;
        for (int i = 0; i < LEN; i++) mem[i] = '1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_we", mat_we, 0);
        check("rst_addr", mat_addr, 0);
        check("rst_data", mat_D, 0);
        check("rst_ready", in_ready, 0);
        check("rst_short", short_load, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        check("idle_ready", in_ready, 0);

        // 1: row-major full load
        run_load(1'b0, LEN - 1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < LEN; i++) check("t1_store", mem[i], i + 1);

        // 2: transposed full load
        run_load(1'b1, LEN - 1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("t2_store1", mem[1], 5);
        check("t2_store4", mem[4], 2);

        // 3: short stream, zero fill
        run_load(1'b0, 4, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        check("t3_store4", mem[4], 5);
        check("t3_store5", mem[5], 0);
        check("t3_store15", mem[15], 0);
        repeat (4) @(negedge clk);
        check("t3_short_sticky", short_load, 1);

        // 4: random valid gaps
        run_load(1'b0, LEN - 1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < LEN; i++) check("t4_store", mem[i], i + 1);

        // 5: reset mid-load, then a transposed reload overwrites everything
        base = done_cnt;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int k = 0; k < 7; k++) begin
            in_valid = 1'b1; in_data = DW'(k + 1);
            push_exp(k, 1'b0, k + 1, 1'b1);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        rst_n    = 1'b0;
        @(negedge clk);
        check("t5_we_in_rst", mat_we, 0);
        check("t5_busy_in_rst", busy, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        check("t5_busy_after", busy, 0);
        check("t5_ready_after", in_ready, 0);
        repeat (3) @(negedge clk);
        check("t5_no_done", done_cnt - base, 0);
        check("t5_queue", expq.size(), 0);
        run_load(1'b1, LEN - 1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int a = 0; a < LEN; a++) check("t5_store", mem[a], map_addr(a, 1'b1) + 1);

        // 6: start pokes during LOAD/FILL/DONE; last on the final element is ignored
        run_load(1'b0, LEN - 1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        run_load(1'b1, 9, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
